// File: rtl/ahb_mailbox_fifo.sv
// AHB-Lite mailbox: firmware word writes feed a FIFO drained over valid/ready.
// Define AHB_MBOX_WAIT_EN to stall full-FIFO writes instead of dropping them.
module ahb_mailbox_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ahb_hsel_i,
  input  logic [31:0] ahb_haddr_i,
  input  logic        ahb_hwrite_i,
  input  logic [2:0]  ahb_hsize_i,
  input  logic [1:0]  ahb_htrans_i,
  input  logic [31:0] ahb_hwdata_i,
  input  logic        ahb_hready_i,
  output logic        ahb_hreadyout_o,
  output logic        ahb_hresp_o,
  output logic [31:0] ahb_hrdata_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;

  logic          ap_valid;
  logic          ap_write;
  logic          ap_size_ok;
  logic [1:0]    ap_addr;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic          empty;
  logic          full;
  logic          dp_wr;
  logic          wr_done;
  logic          data_wr;
  logic          ctrl_wr;
  logic          flush;
  logic          ovf_clr;
  logic          pop_raw;
  logic          pop;
  logic          push;
  logic          drop;

  logic          unused_bits;

  assign unused_bits = ^{ahb_haddr_i[31:4],
                         ahb_haddr_i[1:0],
                         ahb_htrans_i[0]};

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign out_valid_o = ~empty;
  assign out_data_o  = empty ? '0 : mem[rd_ptr];
  assign ahb_hresp_o = 1'b0;

  assign dp_wr   = ap_valid & ap_write & ap_size_ok;
  assign pop_raw = out_valid_o & out_ready_i;

`ifdef AHB_MBOX_WAIT_EN
  // Hold the bus while a DATA write targets a full FIFO with no pop
  assign ahb_hreadyout_o =
    ~(dp_wr & (ap_addr == A_DATA) & full & ~pop_raw);
`else
  assign ahb_hreadyout_o = 1'b1;
`endif

  assign wr_done = dp_wr & ahb_hreadyout_o;
  assign data_wr = wr_done & (ap_addr == A_DATA);
  assign ctrl_wr = wr_done & (ap_addr == A_CTRL);
  assign flush   = ctrl_wr & ahb_hwdata_i[0];
  assign ovf_clr = ctrl_wr & ahb_hwdata_i[1];

  // A flush discards whatever the consumer took in that cycle
  assign pop  = pop_raw & ~flush;
  assign push = data_wr & (~full | pop);

`ifdef AHB_MBOX_WAIT_EN
  assign drop = 1'b0;
`else
  assign drop = data_wr & full & ~pop;
`endif

  // Capture the address phase whenever the bus advances
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ap_valid   <= 1'b0;
      ap_write   <= 1'b0;
      ap_size_ok <= 1'b0;
      ap_addr    <= '0;
    end else if (ahb_hready_i) begin
      ap_valid   <= ahb_hsel_i & ahb_htrans_i[1];
      ap_write   <= ahb_hwrite_i;
      ap_size_ok <= (ahb_hsize_i == 3'b010);
      ap_addr    <= ahb_haddr_i[3:2];
    end
  end

  // Pointer and fill-level bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= ahb_hwdata_i;
  end

  // Sticky overflow; a same-cycle set beats the clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  // Read data for the captured address, from pre-edge state
  always_comb begin
    ahb_hrdata_o = '0;
    if (ap_valid && !ap_write && ap_addr == A_STAT) begin
      ahb_hrdata_o[CW-1:0] = count;
      ahb_hrdata_o[16]     = empty;
      ahb_hrdata_o[17]     = full;
      ahb_hrdata_o[18]     = overflow;
    end
  end

endmodule

// File: tb/tb_ahb_mailbox_fifo.sv
// Scoreboard bench for ahb_mailbox_fifo: queue model of the mailbox
// checked every cycle; honours AHB_MBOX_WAIT_EN when defined.
module tb_ahb_mailbox_fifo;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [1:0]  addr;
    logic [2:0]  size;
    logic [31:0] data;
  } txn_t;

  logic        clk;
  logic        resetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  ahb_mailbox_fifo #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ahb_hsel_i      (hsel),
    .ahb_haddr_i     (haddr),
    .ahb_hwrite_i    (hwrite),
    .ahb_hsize_i     (hsize),
    .ahb_htrans_i    (htrans),
    .ahb_hwdata_i    (hwdata),
    .ahb_hready_i    (hreadyout),
    .ahb_hreadyout_o (hreadyout),
    .ahb_hresp_o     (hresp),
    .ahb_hrdata_o    (hrdata),
    .out_valid_o     (out_valid),
    .out_data_o      (out_data),
    .out_ready_i     (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  txn_t        ap_t;
  txn_t        dp_t;
  txn_t        pend_q[$];
  logic [31:0] exp_q[$];
  logic        exp_ovf;
  logic        stall;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_word();
    logic [31:0] r;
    r     = 32'(exp_q.size());
    r[16] = (exp_q.size() == 0);
    r[17] = (exp_q.size() == DEPTH);
    r[18] = exp_ovf;
    return r;
  endfunction

  // Model + monitor: check outputs mid-cycle, then apply this cycle's events
  always @(negedge clk) begin
    logic        dv, wr, full, pop_req, rdy;
    logic        flush, clr, pop, push_req;
    logic [31:0] er;
    if (!resetn) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      stall   = 1'b0;
    end else begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0)
        chk("out_data", out_data, exp_q[0]);
      else
        chk("out_data_empty", out_data, 32'h0);
      chk("hresp", {31'b0, hresp}, 32'h0);
      dv       = dp_t.sel & dp_t.trans[1];
      wr       = dv & dp_t.write & (dp_t.size == 3'b010);
      full     = (exp_q.size() == DEPTH);
      pop_req  = (exp_q.size() != 0) && out_ready;
      rdy      = 1'b1;
`ifdef AHB_MBOX_WAIT_EN
      if (wr && dp_t.addr == 2'd0 && full && !pop_req)
        rdy = 1'b0;
`endif
      chk("hreadyout", {31'b0, hreadyout}, {31'b0, rdy});
      if (dv && !dp_t.write) begin
        er = (dp_t.addr == 2'd1) ? status_word() : 32'h0;
        chk("hrdata", hrdata, er);
      end
      flush    = rdy && wr && dp_t.addr == 2'd2 && dp_t.data[0];
      clr      = rdy && wr && dp_t.addr == 2'd2 && dp_t.data[1];
      push_req = rdy && wr && dp_t.addr == 2'd0;
      pop      = pop_req && !flush;
      if (flush)
        exp_q.delete();
      else if (pop)
        void'(exp_q.pop_front());
      if (push_req) begin
        if (!full || pop)
          exp_q.push_back(dp_t.data);
        else
          exp_ovf = 1'b1;
      end
      if (clr)
        exp_ovf = 1'b0;
      stall = !rdy;
    end
  end

  // Advance the bus pipeline one cycle unless the slave is stalling
  task automatic step(input logic rdy);
    @(posedge clk);
    #1;
    if (!stall) begin
      dp_t = ap_t;
      if (pend_q.size() != 0)
        ap_t = pend_q.pop_front();
      else
        ap_t = '0;
    end
    hsel      = ap_t.sel;
    htrans    = ap_t.trans;
    haddr     = {$urandom_range(0, 15) << 4, ap_t.addr, 2'b00};
    hwrite    = ap_t.write;
    hsize     = ap_t.size;
    hwdata    = dp_t.data;
    out_ready = rdy;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      step(rdy);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input logic [2:0] sz);
    txn_t t;
    t = '{sel: 1'b1, trans: 2'b10, write: 1'b1, addr: a, size: sz, data: d};
    pend_q.push_back(t);
  endtask

  task automatic rd(input logic [1:0] a);
    txn_t t;
    t = '{sel: 1'b1, trans: 2'b10, write: 1'b0, addr: a,
          size: 3'b010, data: 32'h0};
    pend_q.push_back(t);
  endtask

  task automatic bus_idle();
    ap_t   = '0;
    dp_t   = '0;
    pend_q.delete();
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = 3'b010;
    hwdata = '0;
    out_ready = 1'b0;
  endtask

  task automatic reset_now();
    #1;
    resetn = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic rand_txn();
    txn_t t;
    t.sel   = ($urandom_range(0, 7) != 0);
    t.trans = 2'($urandom_range(0, 3));
    t.write = ($urandom_range(0, 3) != 0);
    t.addr  = ($urandom_range(0, 7) < 5) ? 2'd0 : 2'($urandom_range(0, 3));
    t.size  = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
    t.data  = $urandom;
    if (t.addr == 2'd2)
      t.data = {30'h0, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0)};
    pend_q.push_back(t);
  endtask

  initial begin
    int rate;
    n_chk   = 0;
    n_fail  = 0;
    exp_ovf = 1'b0;
    stall   = 1'b0;
    resetn  = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state via STATUS
    rd(2'd1);
    run(3, 1'b0);

    // Three back-to-back words, then drain
    wr(2'd0, 32'hA5A5_0001, 3'b010);
    wr(2'd0, 32'hA5A5_0002, 3'b010);
    wr(2'd0, 32'hA5A5_0003, 3'b010);
    rd(2'd1);
    run(6, 1'b0);
    run(5, 1'b1);
    rd(2'd1);
    run(3, 1'b0);

    // Fill to DEPTH, then one more word
    for (int i = 0; i < DEPTH; i++)
      wr(2'd0, 32'hB000_0000 + 32'(i), 3'b010);
    run(DEPTH + 2, 1'b0);
`ifdef AHB_MBOX_WAIT_EN
    wr(2'd0, 32'hDEAD_BEEF, 3'b010);
    run(5, 1'b0);
    run(1, 1'b1);
    rd(2'd1);
    run(3, 1'b0);
`else
    wr(2'd0, 32'hC0DE_0017, 3'b010);
    rd(2'd1);
    run(4, 1'b0);
    wr(2'd2, 32'h2, 3'b010);
    rd(2'd1);
    run(4, 1'b0);
`endif

    // Full FIFO with a push coinciding with a pop
    wr(2'd0, 32'hE000_0001, 3'b010);
    run(1, 1'b0);
    run(1, 1'b1);
    rd(2'd1);
    run(3, 1'b0);

    // Flush with five entries, then a halfword DATA write
    wr(2'd2, 32'h1, 3'b010);
    run(3, 1'b0);
    for (int i = 0; i < 5; i++)
      wr(2'd0, 32'hF000_0000 + 32'(i), 3'b010);
    rd(2'd1);
    wr(2'd2, 32'h1, 3'b010);
    rd(2'd1);
    wr(2'd0, 32'h1234_5678, 3'b001);
    rd(2'd1);
    run(12, 1'b0);

    // Reserved register and reads of DATA/CTRL
    wr(2'd3, 32'hFFFF_FFFF, 3'b010);
    rd(2'd0);
    rd(2'd2);
    rd(2'd3);
    run(6, 1'b0);

    // Reset in the middle of a DATA write data phase
    wr(2'd0, 32'h5555_AAAA, 3'b010);
    run(2, 1'b0);
    reset_now();
    rd(2'd1);
    run(3, 1'b0);

    // Randomized traffic with varying consumer rate
    for (int blk = 0; blk < 8; blk++) begin
      rate = $urandom_range(0, 4);
      for (int i = 0; i < 60; i++)
        rand_txn();
      for (int c = 0; c < 400 && pend_q.size() != 0; c++)
        step($urandom_range(0, 3) < rate);
      if (pend_q.size() != 0)
        chk("rand_progress", 32'(pend_q.size()), 32'h0);
    end

    // Drain and final status
    run(DEPTH + 4, 1'b1);
    rd(2'd1);
    run(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mailbox_fifo.md
# ahb_mailbox_fifo

AHB-Lite slave that consumes the CPU core's AHB master port and buffers 32-bit words written by firmware into a FIFO. The FIFO is drained by a downstream hardware consumer, for example the classifier result/command path, over a valid/ready stream. A status register lets firmware poll fill level and a sticky overflow flag. A control register provides flush and overflow-clear.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in words; power of 2, 2..256.
- CW, $clog2(DEPTH)+1, count width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low. One clock; all state clears immediately on resetn low.
- ahb_hsel_i  in  1  slave select.
- ahb_haddr_i  in  32  address; only [3:2] decoded.
- ahb_hwrite_i  in  1  1 = write.
- ahb_hsize_i  in  3  transfer size; only 3'b010 (word) is honoured.
- ahb_htrans_i  in  2  IDLE/BUSY/NONSEQ/SEQ.
- ahb_hwdata_i  in  32  write data, data phase.
- ahb_hready_i  in  1  bus-level HREADY.
- ahb_hreadyout_o  out  1  slave ready.
- ahb_hresp_o  out  1  always 0 (OKAY).
- ahb_hrdata_o  out  32  read data, data phase.
- out_valid_o  out  1  FIFO non-empty.
- out_data_o  out  32  FIFO head word (show-ahead).
- out_ready_i  in  1  consumer accepts head.

## Operation
Register map, haddr[3:2]:
- 0: DATA.
  - Write pushes hwdata.
  - Read returns 0.
- 1: STATUS (read-only).
  - [CW-1:0] count.
  - [16] empty.
  - [17] full.
  - [18] overflow (sticky).
  - Other bits 0.
- 2: CTRL (write-only, self-clearing).
  - bit0 = flush.
  - bit1 = clear overflow.
  - Reads return 0.
- 3: reserved; writes ignored, reads return 0.

AHB protocol:
- Address phase is captured when ahb_hsel_i & ahb_htrans_i[1] & ahb_hready_i. The block registers the write flag, the address bits [3:2] and a size-ok flag.
- Data phase is the following cycle(s).
  - Writes act on ahb_hwdata_i in the final data-phase cycle, i.e. the cycle with ahb_hreadyout_o = 1.
  - Non-word writes are ignored.
- ahb_hrdata_o is combinational from the captured address and current state, and is valid throughout the data phase.
- IDLE and BUSY transfers have no effect.

FIFO rules:
- Storage: DEPTH x 32 array, rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus a CW-bit count.
- Pop occurs when out_valid_o & out_ready_i.
- Push (DATA write) is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - A simultaneous push and pop leave count unchanged.
- A push that is not accepted is dropped and sets overflow. This applies only when AHB_MBOX_WAIT_EN is undefined.
- Flush resets pointers and count to 0 and does not alter overflow.
  - A pop in the same cycle as a flush is ignored.
  - The consumer must not rely on data presented in the flush cycle.
- Clear-overflow clears the sticky flag.
  - If an overflow event occurs in the same cycle, set wins.

Reset values:
- ahb_hreadyout_o = 1.
- ahb_hresp_o = 0.
- ahb_hrdata_o = 0.
- out_valid_o = 0.
- out_data_o = 0 while empty.
- count = 0, overflow = 0, pointers = 0.
- Captured address-phase state cleared (no pending transfer).

## Timing
- Write to DATA: push is visible the cycle after the data phase completes. out_valid_o rises and count increments 1 cycle after the data-phase cycle.
- Back-to-back pipelined writes sustain 1 word/cycle.
- Pop: out_data_o advances to the next word the cycle after the pop.
- STATUS read reflects state as registered at the start of the data-phase cycle. A push or pop in that same cycle is not reflected.
- Write-after-STATUS-read needs no bubbles; a zero-wait pipeline is guaranteed in default configuration.
- Reset asserted mid-transfer aborts it. The transfer completes with hreadyout = 1 and no push occurs.

## Configuration
- AHB_MBOX_WAIT_EN undefined (default): ahb_hreadyout_o is tied to 1. A full-FIFO DATA write is dropped and sets overflow.
- AHB_MBOX_WAIT_EN defined: a DATA write data phase with FIFO full and no same-cycle pop drives ahb_hreadyout_o = 0.
  - Wait states are inserted until a pop frees a slot.
  - The write completes, and the push occurs, in the cycle the pop occurs; hreadyout returns to 1 in that cycle.
  - Overflow is never set.
  - Flush cannot occur during the stall because the bus is held.
  - hwdata is sampled at completion.

## Test plan
- Reset then read STATUS -> 0x0001_0000 (empty=1, count=0); out_valid_o = 0.
- Write 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003 back-to-back with out_ready_i = 0 -> count = 3.
  - Then set out_ready_i = 1 -> out_data_o presents 0xA5A5_0001, _0002, _0003 on consecutive cycles.
  - out_valid_o drops after the third pop.
- DEPTH = 16: write 17 words with out_ready_i = 0 -> STATUS = 0x0006_0010 (full, overflow, count 16).
  - The 17th word never appears on out_data_o.
  - Write CTRL = 0x2 -> overflow clears.
- Full FIFO, DATA write coinciding with a pop -> push accepted, count stays 16, overflow stays 0.
- Write CTRL = 0x1 with count = 5 -> next cycle count = 0, out_valid_o = 0, overflow unchanged.
  - A halfword write to DATA then leaves count = 0.
- With AHB_MBOX_WAIT_EN: full FIFO, write 0xDEAD_BEEF -> hreadyout_o low for 4 cycles.
  - Assert out_ready_i for one cycle -> write completes that cycle, 0xDEAD_BEEF becomes the tail, overflow = 0.
